bump_nav_ctrl: RTL

BUMP_NAV_CTRL -- requirements
Module: bump_nav_ctrl

---
 rtl/bump_nav_pkg.sv | 37 +++
 rtl/bump_nav_ctrl_if.sv | 33 +++
 rtl/bump_nav_ctrl_tick_gen.sv | 33 +++
 rtl/bump_nav_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bump_nav_pkg.sv
// Shared definitions for the bump-and-turn navigation controller.
// Contents: FSM state type, turn-direction type, motor decode constants,
// and a helper that sizes the maneuver tick timer.
package bump_nav_pkg;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_FWD,
    ST_BACK,
    ST_TURN
  } state_t;

  typedef enum logic {
    TURN_LEFT,
    TURN_RIGHT
  } turn_dir_t;

  // Motor enables are active-low, directions are 1 = forward.
  typedef struct packed {
    logic le;
    logic re;
    logic ldir;
    logic rdir;
  } motor_t;

  localparam motor_t DEC_STOP   = motor_t'(4'b1111);
  localparam motor_t DEC_FWD    = motor_t'(4'b0011);
  localparam motor_t DEC_BACK   = motor_t'(4'b0000);
  localparam motor_t DEC_TURN_L = motor_t'(4'b0001);
  localparam motor_t DEC_TURN_R = motor_t'(4'b0010);

  // Timer must hold the doubled reverse length as well as the turn length.
  function automatic int timer_width(input int back_ticks, input int turn_ticks);
    return $clog2(2 * back_ticks + turn_ticks + 1);
  endfunction

endpackage

// File: rtl/bump_nav_ctrl_if.sv
// Drive/sensor bundle of bump_nav_ctrl.
//   run            : drive enable (1 = go)
//   R_bump, L_bump : bumper switches, active-low, asynchronous
//   Le, Re         : motor enables, active-low
//   Ldir, Rdir     : motor directions, 1 = forward
//   busy           : high while reversing or turning
//   man_cnt        : saturating count of maneuvers started
// master = the side driving run/bumpers, slave = the controller.
interface bump_nav_ctrl_if #(
  parameter int CNT_W = 8
);

  logic             run;
  logic             R_bump;
  logic             L_bump;
  logic             Le;
  logic             Re;
  logic             Ldir;
  logic             Rdir;
  logic             busy;
  logic [CNT_W-1:0] man_cnt;

  modport master (
    output run, R_bump, L_bump,
    input  Le, Re, Ldir, Rdir, busy, man_cnt
  );

  modport slave (
    input  run, R_bump, L_bump,
    output Le, Re, Ldir, Rdir, busy, man_cnt
  );

endinterface

// File: rtl/bump_nav_ctrl_tick_gen.sv
// tick_gen: free-running maneuver tick divider.
//   clk   : clock
//   reset : asynchronous active-low reset
//   clr   : synchronous restart at count 0
//   tick  : one-cycle pulse while the count sits at TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 2080000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Not gated by clr: the controller derives clr from tick.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/bump_nav_ctrl.sv
// bump_nav_ctrl: bumper-driven navigation controller.
// Drives forward while run=1; on a bumper hit it reverses for BACK_TICKS
// ticks (doubled when both bumpers hit together), turns away for
// TURN_TICKS ticks, then resumes forward.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : bump_nav_ctrl_if.slave (run, bumpers in; motor controls,
//           busy and man_cnt out)
// Build option: define BUMP_DEBOUNCE_EN to require a bumper to stay low for
// DB_TICKS consecutive ticks before it is accepted.
module bump_nav_ctrl
  import bump_nav_pkg::*;
#(
  parameter int TICK_DIV   = 2080000,
  parameter int BACK_TICKS = 2,
  parameter int TURN_TICKS = 2,
  parameter int DB_TICKS   = 1,
  parameter int CNT_W      = 8
) (
  input logic            clk,
  input logic            reset,
  bump_nav_ctrl_if.slave bus
);

  localparam int TW = timer_width(BACK_TICKS, TURN_TICKS);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be >= 2");
  end
  if (BACK_TICKS < 1 || TURN_TICKS < 1) begin : g_bad_ticks
    $error("BACK_TICKS and TURN_TICKS must be >= 1");
  end
  if (DB_TICKS < 1) begin : g_bad_db
    $error("DB_TICKS must be >= 1");
  end

  // Bumper synchronizers; idle (released) value is high.
  logic [1:0] r_sync;
  logic [1:0] l_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      l_sync <= '1;
    end else begin
      r_sync <= {r_sync[0], bus.R_bump};
      l_sync <= {l_sync[0], bus.L_bump};
    end
  end

  logic tick;
  logic clr_tick;
  logic r_acc;
  logic l_acc;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_tick),
    .tick (tick)
  );

`ifdef BUMP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_TICKS + 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DB_TICKS);

  logic [DB_W-1:0] db_r;
  logic [DB_W-1:0] db_l;

  // Count ticks seen while low; any high cycle restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_r <= '0;
      db_l <= '0;
    end else begin
      if (r_sync[1]) begin
        db_r <= '0;
      end else if (tick && (db_r != DB_FULL)) begin
        db_r <= db_r + 1'b1;
      end
      if (l_sync[1]) begin
        db_l <= '0;
      end else if (tick && (db_l != DB_FULL)) begin
        db_l <= db_l + 1'b1;
      end
    end
  end

  assign r_acc = (db_r == DB_FULL);
  assign l_acc = (db_l == DB_FULL);
`else
  assign r_acc = ~r_sync[1];
  assign l_acc = ~l_sync[1];
`endif

  state_t           state;
  turn_dir_t        turn_dir;
  motor_t           mot;
  logic             busy_q;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] man_cnt_q;

  logic enter_back;
  logic tmr_last;

  always_comb begin
    enter_back = (state == ST_FWD) && (r_acc || l_acc);
    tmr_last   = tick && (timer == TW'(1));
    clr_tick   = bus.run && (enter_back || ((state == ST_BACK) && tmr_last));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_STOP;
      turn_dir  <= TURN_LEFT;
      mot       <= DEC_STOP;
      busy_q    <= 1'b0;
      timer     <= '0;
      man_cnt_q <= '0;
    end else if (!bus.run) begin
      state  <= ST_STOP;
      mot    <= DEC_STOP;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_STOP: begin
          state <= ST_FWD;
          mot   <= DEC_FWD;
        end
        ST_FWD: begin
          if (enter_back) begin
            state    <= ST_BACK;
            mot      <= DEC_BACK;
            busy_q   <= 1'b1;
            turn_dir <= r_acc ? TURN_LEFT : TURN_RIGHT;
            timer    <= (r_acc && l_acc) ? TW'(2 * BACK_TICKS) : TW'(BACK_TICKS);
            if (man_cnt_q != '1) begin
              man_cnt_q <= man_cnt_q + 1'b1;
            end
          end
        end
        ST_BACK: begin
          if (tmr_last) begin
            state <= ST_TURN;
            timer <= TW'(TURN_TICKS);
            mot   <= (turn_dir == TURN_LEFT) ? DEC_TURN_L : DEC_TURN_R;
          end else if (tick) begin
            timer <= timer - 1'b1;
          end
        end
        ST_TURN: begin
          if (tmr_last) begin
            state  <= ST_FWD;
            mot    <= DEC_FWD;
            busy_q <= 1'b0;
          end else if (tick) begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state  <= ST_STOP;
          mot    <= DEC_STOP;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Le      = mot.le;
  assign bus.Re      = mot.re;
  assign bus.Ldir    = mot.ldir;
  assign bus.Rdir    = mot.rdir;
  assign bus.busy    = busy_q;
  assign bus.man_cnt = man_cnt_q;

endmodule
